// File: rtl/ifid_stall_pipe_pkg.sv
// Shared constants for the front-end pipeline registers: the NOP encoding,
// the control bubble, the PC step and the default reset PC.
package pipe_pkg;

   localparam int          CTRL_W_DEFAULT   = 10;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUBBLE = '0;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Sequential PC of an instruction; the carry out of bit 31 is dropped.
   function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/ifid_stall_pipe_if.sv
// Bundle between fetch / hazard detection (master) and the IF/ID stall
// pipeline (slave).
interface ifid_stall_pipe_if #(
   parameter int CTRL_W = 10,
   parameter int CNT_W  = 16
);
   logic [31:0]       pc_next_i;
   logic [31:0]       instr_i;
   logic              pc_write_i;
   logic              ifid_write_i;
   logic              control_select_i;
   logic              ifid_flush_i;
   logic [CTRL_W-1:0] ctrl_i;
   logic [31:0]       pc_o;
   logic [31:0]       ifid_pc4_o;
   logic [31:0]       ifid_instr_o;
   logic              ifid_valid_o;
   logic [CTRL_W-1:0] idex_ctrl_o;
   logic [CNT_W-1:0]  stall_cnt_o;
   logic [CNT_W-1:0]  flush_cnt_o;

   modport master (
      output pc_next_i, instr_i, pc_write_i, ifid_write_i,
             control_select_i, ifid_flush_i, ctrl_i,
      input  pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o,
             idex_ctrl_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  pc_next_i, instr_i, pc_write_i, ifid_write_i,
             control_select_i, ifid_flush_i, ctrl_i,
      output pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o,
             idex_ctrl_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/ifid_stall_pipe_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so a long
// run of events never reads back as a small count.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   function automatic logic [W-1:0] satInc(input logic [W-1:0] v);
      return (&v) ? v : v + W'(1);
   endfunction

   logic [W-1:0] cnt_p0;

   // Count qualifying cycles, holding at the ceiling.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)      cnt_p0 <= '0;
      else if (inc_i) cnt_p0 <= satInc(cnt_p0);
   end

   assign cnt_o = cnt_p0;

endmodule

// File: rtl/ifid_stall_pipe.sv
// PC, IF/ID and ID/EX-control registers driven by the hazard unit's
// stall / bubble / flush requests, plus stall and flush event counters.
module ifid_stall_pipe
   import pipe_pkg::*;
#(
   parameter int          CTRL_W   = 10,
   parameter int          CNT_W    = 16,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input logic              clk_i,
   input logic              rst_i,
   ifid_stall_pipe_if.slave bus
);

   localparam logic [CTRL_W-1:0] BUBBLE = CTRL_W'(CTRL_BUBBLE);

   logic [31:0]       pc_p0;
   logic [31:0]       ifidPc4_p1;
   logic [31:0]       ifidInstr_p1;
   logic              vld_p1;
   logic [CTRL_W-1:0] idexCtrl_p2;

   // ---- fetch PC: loads the fetch-mux choice unless stalled
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)               pc_p0 <= RESET_PC;
      else if (bus.pc_write_i) pc_p0 <= bus.pc_next_i;
   end

   // ---- IF/ID: flush wins over hold, hold wins over load
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ifidPc4_p1   <= '0;
         ifidInstr_p1 <= NOP_INSTR;
         vld_p1       <= 1'b0;
      end else if (bus.ifid_flush_i) begin
         ifidPc4_p1   <= '0;
         ifidInstr_p1 <= NOP_INSTR;
         vld_p1       <= 1'b0;
      end else if (bus.ifid_write_i) begin
         ifidPc4_p1   <= pcPlus4(pc_p0);
         ifidInstr_p1 <= bus.instr_i;
         vld_p1       <= 1'b1;
      end
   end

   // ---- ID/EX control: never held, so every stalled or empty slot becomes a bubble
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                 idexCtrl_p2 <= BUBBLE;
      else if (bus.control_select_i || !vld_p1) idexCtrl_p2 <= BUBBLE;
      else                                       idexCtrl_p2 <= bus.ctrl_i;
   end

   sat_counter #(.W(CNT_W)) uStallCnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (!bus.pc_write_i),
      .cnt_o (bus.stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) uFlushCnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (bus.ifid_flush_i),
      .cnt_o (bus.flush_cnt_o)
   );

   assign bus.pc_o         = pc_p0;
   assign bus.ifid_pc4_o   = ifidPc4_p1;
   assign bus.ifid_instr_o = ifidInstr_p1;
   assign bus.ifid_valid_o = vld_p1;
   assign bus.idex_ctrl_o  = idexCtrl_p2;

endmodule

// File: tb/tb_ifid_stall_pipe.sv
// Directed bench for ifid_stall_pipe: a behavioural model pushes the expected
// register state when each cycle's inputs are driven; it is popped and compared
// just after the clock edge. Counters use CNT_W=4 so saturation is reachable.
module tb_ifid_stall_pipe;
   import pipe_pkg::*;

   localparam int          CTRL_W   = 10;
   localparam int          CNT_W    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0]       pc;
      logic [31:0]       pc4;
      logic [31:0]       instr;
      logic              vld;
      logic [CTRL_W-1:0] ctrl;
      logic [CNT_W-1:0]  sc;
      logic [CNT_W-1:0]  fc;
   } state_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ifid_stall_pipe_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

   ifid_stall_pipe #(.CTRL_W(CTRL_W), .CNT_W(CNT_W), .RESET_PC(RESET_PC)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   state_t m;
   state_t q[$];
   int     nChecks = 0;
   int     nFails  = 0;

   function automatic state_t resetState();
      state_t s;
      s.pc = RESET_PC; s.pc4 = '0; s.instr = '0; s.vld = 1'b0;
      s.ctrl = '0; s.sc = '0; s.fc = '0;
      return s;
   endfunction

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {16'h2000, a[15:0]} ^ 32'h0055_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkState(input string tag, input state_t e);
      chk({tag, ".pc"},    bus.pc_o,                e.pc);
      chk({tag, ".pc4"},   bus.ifid_pc4_o,          e.pc4);
      chk({tag, ".instr"}, bus.ifid_instr_o,        e.instr);
      chk({tag, ".vld"},   32'(bus.ifid_valid_o),   32'(e.vld));
      chk({tag, ".ctrl"},  32'(bus.idex_ctrl_o),    32'(e.ctrl));
      chk({tag, ".scnt"},  32'(bus.stall_cnt_o),    32'(e.sc));
      chk({tag, ".fcnt"},  32'(bus.flush_cnt_o),    32'(e.fc));
   endtask

   // Drive one cycle of inputs (called in the low phase), model it, then compare after the edge.
   task automatic cycle(input string tag, input logic pcWr, input logic ifWr, input logic csel,
                        input logic flush, input logic [31:0] pcNext, input logic [31:0] instr,
                        input logic [CTRL_W-1:0] ctrl);
      state_t n;
      state_t e;
      bus.pc_write_i       = pcWr;
      bus.ifid_write_i     = ifWr;
      bus.control_select_i = csel;
      bus.ifid_flush_i     = flush;
      bus.pc_next_i        = pcNext;
      bus.instr_i          = instr;
      bus.ctrl_i           = ctrl;
      n = m;
      if (pcWr) n.pc = pcNext;
      if (flush) begin
         n.pc4 = '0; n.instr = 32'h0; n.vld = 1'b0;
      end else if (ifWr) begin
         n.pc4 = m.pc + 32'd4; n.instr = instr; n.vld = 1'b1;
      end
      n.ctrl = (csel || !m.vld) ? '0 : ctrl;
      if (!pcWr && m.sc != {CNT_W{1'b1}}) n.sc = m.sc + 1'b1;
      if (flush && m.fc != {CNT_W{1'b1}}) n.fc = m.fc + 1'b1;
      q.push_back(n);
      m = n;
      @(posedge clk);
      #1;
      e = q.pop_front();
      chkState(tag, e);
      @(negedge clk);
   endtask

   task automatic fetch(input string tag, input logic [CTRL_W-1:0] ctrl);
      cycle(tag, 1'b1, 1'b1, 1'b0, 1'b0, m.pc + 32'd4, memWord(m.pc), ctrl);
   endtask

   initial begin
      bus.pc_write_i = 1'b1; bus.ifid_write_i = 1'b1; bus.control_select_i = 1'b0;
      bus.ifid_flush_i = 1'b0; bus.pc_next_i = '0; bus.instr_i = '0; bus.ctrl_i = '0;
      m = resetState();

      // Reset values
      #2;
      chkState("reset", m);
      @(negedge clk);
      rst = 1'b0;

      // First instruction after reset release
      cycle("first", 1'b1, 1'b1, 1'b0, 1'b0, 32'd4, 32'h8C01_0004, 10'h155);
      chk("first.instr_const", bus.ifid_instr_o, 32'h8C01_0004);
      chk("first.pc4_const",   bus.ifid_pc4_o,   32'd4);
      chk("first.ctrl_bubble", 32'(bus.idex_ctrl_o), 32'h0);
      fetch("run1", 10'h101);
      chk("run1.ctrl_pass", 32'(bus.idex_ctrl_o), 32'h101);
      fetch("run2", 10'h102);
      fetch("run3", 10'h103);

      // One-cycle load-use stall at pc 0x10
      cycle("stall", 1'b0, 1'b0, 1'b1, 1'b0, 32'h14, memWord(32'h10), 10'h2AA);
      chk("stall.pc_held", bus.pc_o, 32'h10);
      chk("stall.bubble", 32'(bus.idex_ctrl_o), 32'h0);
      chk("stall.cnt", 32'(bus.stall_cnt_o), 32'd1);
      fetch("resume", 10'h0F0);
      chk("resume.ctrl_pass", 32'(bus.idex_ctrl_o), 32'h0F0);

      // Taken-branch flush, then empty slot bubbles without control_select
      cycle("flush", 1'b1, 1'b1, 1'b0, 1'b1, 32'h40, memWord(m.pc), 10'h111);
      chk("flush.instr", bus.ifid_instr_o, 32'h0);
      chk("flush.vld",   32'(bus.ifid_valid_o), 32'h0);
      chk("flush.cnt",   32'(bus.flush_cnt_o), 32'd1);
      fetch("postflush", 10'h3FF);
      chk("postflush.bubble", 32'(bus.idex_ctrl_o), 32'h0);
      fetch("refill", 10'h077);

      // Flush concurrent with stall
      cycle("flushstall", 1'b0, 1'b0, 1'b1, 1'b1, m.pc + 32'd4, memWord(m.pc), 10'h1C3);
      chk("flushstall.pc", bus.pc_o, 32'h48);
      chk("flushstall.scnt", 32'(bus.stall_cnt_o), 32'd2);
      chk("flushstall.fcnt", 32'(bus.flush_cnt_o), 32'd2);

      // PC+4 wrap at the top of the address space
      cycle("jumptop", 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, memWord(m.pc), 10'h0AA);
      fetch("wrap", 10'h0AB);
      chk("wrap.pc4", bus.ifid_pc4_o, 32'h0);

      // PC loads while IF/ID holds (fetched word dropped)
      cycle("pcOnly", 1'b1, 1'b0, 1'b0, 1'b0, m.pc + 32'd4, 32'hDEAD_BEEF, 10'h0CC);

      // Long stall saturates the stall counter
      for (int i = 0; i < 20; i++)
         cycle("longstall", 1'b0, 1'b0, 1'b1, 1'b0, m.pc + 32'd4, memWord(m.pc), 10'(i));
      chk("sat.scnt", 32'(bus.stall_cnt_o), 32'hF);

      // Asynchronous reset mid-stall, between edges
      bus.pc_write_i = 1'b0; bus.ifid_write_i = 1'b0; bus.control_select_i = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      m = resetState();
      q.delete();
      chkState("asyncrst", m);
      #1;
      rst = 1'b0;
      cycle("refetch", 1'b1, 1'b1, 1'b0, 1'b0, RESET_PC + 32'd4, memWord(RESET_PC), 10'h155);
      chk("refetch.pc4", bus.ifid_pc4_o, 32'd4);
      fetch("refetch2", 10'h056);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/ifid_stall_pipe.md
# ifid_stall_pipe

Front-end pipeline register block that carries out the stall and bubble requests produced by the hazard detection logic. It holds the PC, the IF/ID register (PC+4, instruction, valid) and the ID/EX control field. It freezes the PC and IF/ID on load-use stalls, injects control bubbles into ID/EX, and squashes IF/ID on branch flushes. It sits between instruction fetch and the register-file/control decode, and also exposes saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- `CTRL_W`, 10: width of the decode-stage control bundle.
- `CNT_W`, 16: width of each event counter.
- `RESET_PC`, 32'h0000_0000: PC value after reset.

Ports:
- `clk_i`  in  1  single clock, all state on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `pc_next_i`  in  32  next PC selected by fetch mux (PC+4 or branch target).
- `instr_i`  in  32  instruction memory data for address `pc_o`.
- `pc_write_i`  in  1  1 = load PC, 0 = hold (stall).
- `ifid_write_i`  in  1  1 = load IF/ID, 0 = hold (stall).
- `control_select_i`  in  1  1 = replace decode control with bubble.
- `ifid_flush_i`  in  1  1 = squash IF/ID (taken branch/jump).
- `ctrl_i`  in  CTRL_W  control bundle decoded from `ifid_instr_o`.
- `pc_o`  out  32  current fetch PC.
- `ifid_pc4_o`  out  32  PC+4 of instruction in IF/ID.
- `ifid_instr_o`  out  32  instruction in IF/ID.
- `ifid_valid_o`  out  1  IF/ID holds a real instruction.
- `idex_ctrl_o`  out  CTRL_W  control bundle in ID/EX.
- `stall_cnt_o`  out  CNT_W  cycles with `pc_write_i`=0.
- `flush_cnt_o`  out  CNT_W  cycles with `ifid_flush_i`=1.

## Operation
- PC: `pc_write_i`=1 → `pc_o` <= `pc_next_i`; otherwise hold.
- IF/ID, priority flush > hold > load:
  - `ifid_flush_i`=1: instr <= NOP (32'h0), pc4 <= 0, valid <= 0.
  - else `ifid_write_i`=0: hold all three fields.
  - else: pc4 <= `pc_o`+4 (mod 2^32, carry dropped), instr <= `instr_i`, valid <= 1.
- ID/EX control: `control_select_i`=1 or `ifid_valid_o`=0 → `idex_ctrl_o` <= 0 (bubble); else `idex_ctrl_o` <= `ctrl_i`. The ID/EX register is never held, so a bubble enters every stalled cycle.
- Counters: `stall_cnt_o` +1 on each cycle with `pc_write_i`=0; `flush_cnt_o` +1 on each cycle with `ifid_flush_i`=1. Both saturate at all-ones and do not wrap.
- Flush concurrent with stall: IF/ID is flushed. PC still obeys `pc_write_i`. Both counters increment.
- `pc_write_i`=1 with `ifid_write_i`=0 is legal and unchecked: IF/ID holds and the fetched word is dropped.
- Reset mid-stall: all state returns to reset values immediately. The stall is not remembered.

## Timing
- Reset values: `pc_o`=RESET_PC, `ifid_pc4_o`=0, `ifid_instr_o`=0, `ifid_valid_o`=0, `idex_ctrl_o`=0, both counters 0.
- All outputs are registered, with 1-cycle latency from the sampled inputs. There is no combinational input-to-output path.
- First instruction: reset released before edge 0 → edge 0 loads IF/ID with the instruction at RESET_PC. `ifid_valid_o`=1 after edge 0. `idex_ctrl_o` is non-bubble from edge 1.
- A one-cycle load-use stall (`pc_write_i`=`ifid_write_i`=0, `control_select_i`=1 for 1 cycle) produces exactly one zero `idex_ctrl_o` and repeats the IF/ID instruction once.

## Structure
- Shared package `pipe_pkg`: `NOP_INSTR`=32'h0, `CTRL_BUBBLE`=0 (CTRL_W wide), `PC_STEP`=4, default `RESET_PC`.
- One sub-module, `sat_counter` (params `W`; ports `clk_i`, `rst_i`, `inc_i`, `cnt_o`), instantiated twice for the stall and flush counters.
- The PC, IF/ID and ID/EX registers stay inline in `ifid_stall_pipe`.

## Test plan
- Reset release, RESET_PC=0, all write enables 1, `instr_i`=32'h8C01_0004: after edge 0 → `ifid_instr_o`=32'h8C01_0004, `ifid_pc4_o`=4, `ifid_valid_o`=1, `pc_o`=`pc_next_i`.
- Load-use stall for 1 cycle with `pc_o`=0x10 → `pc_o` stays 0x10, IF/ID unchanged, `idex_ctrl_o`=0 for one cycle, `stall_cnt_o`=1; the next cycle resumes with `ctrl_i` passed through.
- Flush with `ifid_write_i`=1 → `ifid_instr_o`=0, `ifid_valid_o`=0, `ifid_pc4_o`=0; the following cycle `idex_ctrl_o`=0 even with `control_select_i`=0; `flush_cnt_o`=1.
- Flush and stall in the same cycle → IF/ID squashed, PC held, `stall_cnt_o` and `flush_cnt_o` both +1.
- `pc_o`=32'hFFFF_FFFC loaded into IF/ID → `ifid_pc4_o`=0 (wrap). With CNT_W=4 and 20 stall cycles → `stall_cnt_o`=4'hF, held.
- `rst_i` asserted asynchronously between edges during a stall → all outputs take reset values before the next edge; normal fetch from RESET_PC after release.
